reg_wb_arbiter: RTL and testbench
=================================

// Module: reg_wb_arbiter
// PURPOSE
//  Shares the register file's single write port between two sources.
//  - Main pipeline writeback (pipe_*): fixed priority, no backpressure.
//  - Long-latency unit (lu_*: divider, multi-cycle load): valid/ready handshake.
//  Keeps a 32-bit scoreboard of registers with a pending long-latency write and
//  raises hazard_stall to decode on RAW/WAW conflicts. Sits between the WB stage
//  and the register file.
// PARAMETERS
//  STARVE_MAX  default 4   lu wait cycles before a forced lu grant (guard build only)
//  CNT_W       default 3   starvation counter width; must satisfy 2**CNT_W > STARVE_MAX
// PORTS
//  clk            in   1   clock
//  rst            in   1   synchronous, active-high reset
//  pipe_wen       in   1   pipeline writeback valid
//  pipe_waddr     in   5   pipeline dest register
//  pipe_wdata     in   32  pipeline write data
//  pipe_hold      out  1   freeze WB stage this cycle (forced lu slot)
//  lu_valid       in   1   long-latency result valid
//  lu_ready       out  1   lu result accepted this cycle
//  lu_waddr       in   5   lu dest register
//  lu_wdata       in   32  lu result
//  issue_en       in   1   long-latency op issued this cycle
//  issue_addr     in   5   its dest register
//  rd_en_1/rd_en_2      in  1  decode source-read enables
//  rd_addr_1/rd_addr_2  in  5  decode source addresses
//  dst_en         in   1   decode instruction writes a register
//  dst_addr       in   5   its dest register
//  hazard_stall   out  1   decode must stall
//  busy_vec       out  32  scoreboard (bit n = reg n pending)
//  rf_write_en    out  1   to register-file write_en
//  rf_write_addr  out  5   to register-file write_addr
//  rf_write_data  out  32  to register-file write_data
// BEHAVIOUR
//  - Reset: rf_write_* = 0, busy_vec = 0, counter = 0, state = NORMAL. Combinational
//    outputs follow: pipe_hold = 0, lu_ready = !pipe_wen, hazard_stall = 0.
//  - Writes to r0 are legal but never set busy. A pipe write to r0 still occupies
//    the port.
//  - Arbitration (combinational):
//    - NORMAL: lu_ready = !pipe_wen, pipe_hold = 0.
//    - FORCE:  lu_ready = 1, pipe_hold = pipe_wen.
//  - Output stage is registered, latency 1. At the edge:
//    - If pipe_wen && !pipe_hold: rf_write <= pipe_*.
//    - Else if lu_valid && lu_ready: rf_write <= lu_*.
//    - Else rf_write_en <= 0.
//    The register file's read bypass covers the cycle in which rf_write is applied.
//  - Scoreboard:
//    - On an lu handshake edge: clear busy[lu_waddr].
//    - On issue_en && issue_addr != 0: set busy[issue_addr]. Set wins over a
//      same-cycle clear of the same register.
//  - hazard_stall = (rd_en_1 && busy[rd_addr_1]) | (rd_en_2 && busy[rd_addr_2])
//    | (dst_en && busy[dst_addr]). Computed from the current busy_vec only; no
//    same-cycle bypass of clears.
//  - Protocol: the issuer never asserts issue_en to a register that is already
//    busy. The bench flags violations.
//  - lu_* must stay stable while lu_valid && !lu_ready.
//  - Reset mid-operation: pending lu results are dropped and busy is cleared;
//    the lu is reset by the same rst.
// CONFIGURATION
//  - WB_STARVE_GUARD_EN defined:
//    - 2-state FSM NORMAL/FORCE. Counter increments while lu_valid && !lu_ready,
//      saturating at STARVE_MAX.
//    - NORMAL -> FORCE when counter == STARVE_MAX.
//    - FORCE -> NORMAL after exactly one cycle, with counter <= 0.
//    - The counter also clears on any lu handshake.
//  - Undefined: strict pipe priority. FSM and counter are absent, pipe_hold is
//    tied to 0, and lu can starve indefinitely.
// STRUCTURE
//  - Shared header (with the existing bus definitions): REG_ADDR_BUS and DATA_BUS
//    widths, FSM state encodings, STARVE_MAX default.
//  - Sub-module reg_scoreboard holds the busy vector, set/clear logic and the
//    three-way hazard compare. The top level holds arbitration, the FSM and the
//    output register.
// TESTING
//  - Reset: hold rst 2 cycles with all inputs active -> rf_write_en = 0,
//    busy_vec = 0, hazard_stall = 0.
//  - pipe only: pipe_wen=1, waddr=5, wdata=32'hA5A5_0001 -> next cycle
//    rf_write_en=1, addr=5, data=32'hA5A5_0001; lu_ready=0 in the request cycle.
//  - Scoreboard: issue_en addr=7, then rd_addr_1=7 with rd_en_1=1 ->
//    hazard_stall=1 until the lu handshake (lu_waddr=7, data 32'h1234) ->
//    busy[7]=0 and the next cycle writes r7=32'h1234.
//  - Simultaneous: the lu handshake to r9 and issue_en to r9 in the same cycle
//    -> busy[9] stays 1.
//  - Guard on, STARVE_MAX=4: pipe_wen=1 continuously, lu_valid=1 -> lu_ready=0
//    for 4 cycles; 5th cycle lu_ready=1 and pipe_hold=1; lu data is written
//    next cycle; counter then 0.
//  - Guard off, same stimulus for 20 cycles -> lu_ready never 1, pipe_hold
//    always 0.

Source files
------------

// File: rtl/reg_wb_arbiter_pkg.sv
// reg_wb_arbiter_pkg: shared bus widths, writeback arbiter FSM encoding and defaults
package reg_wb_arbiter_pkg;
  localparam int REG_ADDR_BUS = 5;
  localparam int DATA_BUS = 32;
  localparam int NUM_REGS = 1 << REG_ADDR_BUS;
  localparam int STARVE_MAX_DEF = 4;
  typedef enum logic {WB_NORMAL = 1'b0, WB_FORCE = 1'b1} wb_state_e;
endpackage

// File: rtl/reg_wb_arbiter_scoreboard.sv
// reg_scoreboard: busy vector of pending long-latency writes and RAW/WAW hazard detect
//   clr_en/clr_addr : lu handshake clears the destination bit
//   set_en/set_addr : long-latency issue sets the destination bit (r0 never set)
//   rd_*/dst_*      : decode operands compared against the busy vector
//   busy_vec, hazard_stall : current scoreboard and decode stall
module reg_scoreboard
  import reg_wb_arbiter_pkg::*;
(
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    clr_en,
  input  logic [REG_ADDR_BUS-1:0] clr_addr,
  input  logic                    set_en,
  input  logic [REG_ADDR_BUS-1:0] set_addr,
  input  logic                    rd_en_1,
  input  logic [REG_ADDR_BUS-1:0] rd_addr_1,
  input  logic                    rd_en_2,
  input  logic [REG_ADDR_BUS-1:0] rd_addr_2,
  input  logic                    dst_en,
  input  logic [REG_ADDR_BUS-1:0] dst_addr,
  output logic [NUM_REGS-1:0]     busy_vec,
  output logic                    hazard_stall
);
  logic [NUM_REGS-1:0] busy_q, busy_d;
  // set is applied after clear so a same-cycle reissue keeps the register busy
  always_comb begin
    busy_d = busy_q;
    if (clr_en) busy_d[clr_addr] = 1'b0;
    if (set_en && set_addr != '0) busy_d[set_addr] = 1'b1;
  end
  always_ff @(posedge clk) busy_q <= rst ? '0 : busy_d;
  assign busy_vec = busy_q;
  assign hazard_stall = (rd_en_1 && busy_q[rd_addr_1]) || (rd_en_2 && busy_q[rd_addr_2]) ||
                        (dst_en && busy_q[dst_addr]);
endmodule

// File: rtl/reg_wb_arbiter.sv
// reg_wb_arbiter: shares the register-file write port between pipeline WB and a long-latency unit
//   pipe_*        : pipeline writeback, fixed priority, frozen by pipe_hold
//   lu_*          : long-latency result, valid/ready handshake
//   issue_*       : long-latency issue marks its destination busy
//   rd_*/dst_*    : decode operands, hazard_stall when any hits a busy register
//   rf_write_*    : registered write port, one cycle after the granted request
//   WB_STARVE_GUARD_EN : when defined, forces one lu slot after STARVE_MAX lost cycles
module reg_wb_arbiter
  import reg_wb_arbiter_pkg::*;
#(
  parameter int STARVE_MAX = STARVE_MAX_DEF,
  parameter int CNT_W = 3
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    pipe_wen,
  input  logic [REG_ADDR_BUS-1:0] pipe_waddr,
  input  logic [DATA_BUS-1:0]     pipe_wdata,
  output logic                    pipe_hold,
  input  logic                    lu_valid,
  output logic                    lu_ready,
  input  logic [REG_ADDR_BUS-1:0] lu_waddr,
  input  logic [DATA_BUS-1:0]     lu_wdata,
  input  logic                    issue_en,
  input  logic [REG_ADDR_BUS-1:0] issue_addr,
  input  logic                    rd_en_1,
  input  logic                    rd_en_2,
  input  logic [REG_ADDR_BUS-1:0] rd_addr_1,
  input  logic [REG_ADDR_BUS-1:0] rd_addr_2,
  input  logic                    dst_en,
  input  logic [REG_ADDR_BUS-1:0] dst_addr,
  output logic                    hazard_stall,
  output logic [NUM_REGS-1:0]     busy_vec,
  output logic                    rf_write_en,
  output logic [REG_ADDR_BUS-1:0] rf_write_addr,
  output logic [DATA_BUS-1:0]     rf_write_data
);
  if (2 ** CNT_W <= STARVE_MAX) begin : g_cnt_w_check
    $error("CNT_W too narrow for STARVE_MAX");
  end
  logic lu_hs, pipe_sel;
  logic rf_write_en_q, rf_write_en_d;
  logic [REG_ADDR_BUS-1:0] rf_write_addr_q, rf_write_addr_d;
  logic [DATA_BUS-1:0] rf_write_data_q, rf_write_data_d;
  assign lu_hs = lu_valid && lu_ready;
  assign pipe_sel = pipe_wen && !pipe_hold;
`ifdef WB_STARVE_GUARD_EN
  wb_state_e state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  // FORCE is entered on the edge where the counter reaches STARVE_MAX, so the
  // forced slot is the cycle right after the STARVE_MAX-th lost cycle
  always_comb begin
    lu_ready = state_q == WB_FORCE || !pipe_wen;
    pipe_hold = state_q == WB_FORCE && pipe_wen;
    cnt_d = (state_q == WB_FORCE || lu_hs) ? '0 :
            (lu_valid && !lu_ready && cnt_q != CNT_W'(STARVE_MAX)) ? cnt_q + 1'b1 : cnt_q;
    state_d = (state_q == WB_NORMAL && cnt_d == CNT_W'(STARVE_MAX)) ? WB_FORCE : WB_NORMAL;
  end
  always_ff @(posedge clk) begin
    state_q <= rst ? WB_NORMAL : state_d;
    cnt_q <= rst ? '0 : cnt_d;
  end
`else
  assign lu_ready = !pipe_wen;
  assign pipe_hold = 1'b0;
`endif
  always_comb begin
    rf_write_en_d = pipe_sel || lu_hs;
    rf_write_addr_d = pipe_sel ? pipe_waddr : lu_hs ? lu_waddr : rf_write_addr_q;
    rf_write_data_d = pipe_sel ? pipe_wdata : lu_hs ? lu_wdata : rf_write_data_q;
  end
  always_ff @(posedge clk) begin
    rf_write_en_q <= rst ? 1'b0 : rf_write_en_d;
    rf_write_addr_q <= rst ? '0 : rf_write_addr_d;
    rf_write_data_q <= rst ? '0 : rf_write_data_d;
  end
  assign rf_write_en = rf_write_en_q;
  assign rf_write_addr = rf_write_addr_q;
  assign rf_write_data = rf_write_data_q;
  reg_scoreboard u_sb (
    .clk(clk),
    .rst(rst),
    .clr_en(lu_hs),
    .clr_addr(lu_waddr),
    .set_en(issue_en),
    .set_addr(issue_addr),
    .rd_en_1(rd_en_1),
    .rd_addr_1(rd_addr_1),
    .rd_en_2(rd_en_2),
    .rd_addr_2(rd_addr_2),
    .dst_en(dst_en),
    .dst_addr(dst_addr),
    .busy_vec(busy_vec),
    .hazard_stall(hazard_stall)
  );
endmodule

// File: tb/tb_reg_wb_arbiter.sv
// tb_reg_wb_arbiter: scoreboard bench with a behavioural arbiter/busy model and randomized traffic
module tb_reg_wb_arbiter;
  localparam int SM = 4;
`ifdef WB_STARVE_GUARD_EN
  localparam bit GUARD = 1'b1;
`else
  localparam bit GUARD = 1'b0;
`endif
  logic clk = 1'b0, rst = 1'b1;
  logic pipe_wen = 0, pipe_hold, lu_valid = 0, lu_ready, issue_en = 0;
  logic rd_en_1 = 0, rd_en_2 = 0, dst_en = 0, hazard_stall;
  logic rf_write_en;
  logic [4:0] pipe_waddr = 0, lu_waddr = 0, issue_addr = 0, rd_addr_1 = 0, rd_addr_2 = 0;
  logic [4:0] dst_addr = 0, rf_write_addr;
  logic [31:0] pipe_wdata = 0, lu_wdata = 0, rf_write_data, busy_vec;
  typedef struct {
    int due;
    logic [4:0] addr;
    logic [31:0] data;
  } wr_t;
  wr_t exp_q[$];
  logic [4:0] pend_q[$];
  logic [31:0] m_busy = 0;
  int m_wait = 0, cyc = 0, n_cmp = 0, n_err = 0;
  bit mon_on = 0, lu_done = 0;
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;
  reg_wb_arbiter dut (
    .clk(clk), .rst(rst),
    .pipe_wen(pipe_wen), .pipe_waddr(pipe_waddr), .pipe_wdata(pipe_wdata), .pipe_hold(pipe_hold),
    .lu_valid(lu_valid), .lu_ready(lu_ready), .lu_waddr(lu_waddr), .lu_wdata(lu_wdata),
    .issue_en(issue_en), .issue_addr(issue_addr),
    .rd_en_1(rd_en_1), .rd_en_2(rd_en_2), .rd_addr_1(rd_addr_1), .rd_addr_2(rd_addr_2),
    .dst_en(dst_en), .dst_addr(dst_addr), .hazard_stall(hazard_stall), .busy_vec(busy_vec),
    .rf_write_en(rf_write_en), .rf_write_addr(rf_write_addr), .rf_write_data(rf_write_data)
  );
  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", nm, act, exp, cyc);
    end
  endtask
  initial forever begin
    @(posedge clk);
    #2;
    if (mon_on) begin
      automatic bit due = exp_q.size() > 0 && exp_q[0].due == cyc;
      chk("rf_write_en", {31'b0, rf_write_en}, {31'b0, due});
      if (due) begin
        automatic wr_t w = exp_q.pop_front();
        if (rf_write_en) begin
          chk("rf_write_addr", {27'b0, rf_write_addr}, {27'b0, w.addr});
          chk("rf_write_data", rf_write_data, w.data);
        end
      end
    end
  end
  task automatic model_step();
    bit force_c, ready, hold, stall, hs;
    wr_t w;
    if (rst) begin
      exp_q.delete();
      m_busy = 0;
      m_wait = 0;
      return;
    end
    force_c = GUARD && m_wait == SM;
    ready = force_c || !pipe_wen;
    hold = force_c && pipe_wen;
    stall = (rd_en_1 && m_busy[rd_addr_1]) || (rd_en_2 && m_busy[rd_addr_2]) ||
            (dst_en && m_busy[dst_addr]);
    chk("lu_ready", {31'b0, lu_ready}, {31'b0, ready});
    chk("pipe_hold", {31'b0, pipe_hold}, {31'b0, hold});
    chk("hazard_stall", {31'b0, hazard_stall}, {31'b0, stall});
    chk("busy_vec", busy_vec, m_busy);
    hs = lu_valid && ready;
    w.due = cyc + 1;
    if (pipe_wen && !hold) begin
      w.addr = pipe_waddr;
      w.data = pipe_wdata;
      exp_q.push_back(w);
    end else if (hs) begin
      w.addr = lu_waddr;
      w.data = lu_wdata;
      exp_q.push_back(w);
    end
    if (issue_en)
      chk("issue_to_busy", {31'b0, issue_addr != 0 && m_busy[issue_addr] &&
          !(hs && lu_waddr == issue_addr)}, 0);
    if (hs) m_busy[lu_waddr] = 1'b0;
    if (issue_en && issue_addr != 0) m_busy[issue_addr] = 1'b1;
    if (issue_en) pend_q.push_back(issue_addr);
    m_wait = (hs || force_c) ? 0 : (lu_valid && !ready) ? m_wait + 1 : m_wait;
    lu_done = hs;
  endtask
  task automatic step();
    logic [4:0] d;
    @(negedge clk);
    model_step();
    @(posedge clk);
    #1;
    if (lu_done) begin
      lu_valid = 0;
      lu_done = 0;
      d = pend_q.pop_front();
    end
  endtask
  task automatic present_lu(input logic [31:0] data);
    if (!lu_valid && pend_q.size() > 0) begin
      lu_valid = 1;
      lu_waddr = pend_q[0];
      lu_wdata = data;
    end
  endtask
  task automatic idle();
    pipe_wen = 0;
    issue_en = 0;
    rd_en_1 = 0;
    rd_en_2 = 0;
    dst_en = 0;
  endtask
  task automatic reset_run(input int n);
    rst = 1;
    for (int i = 0; i < n; i++) step();
    rst = 0;
    lu_valid = 0;
    lu_done = 0;
    pend_q.delete();
    idle();
  endtask
  initial begin
    pipe_wen = 1; pipe_waddr = 4; pipe_wdata = 32'hFFFF_FFFF;
    lu_valid = 1; lu_waddr = 6; lu_wdata = 32'h5555_5555;
    issue_en = 1; issue_addr = 3;
    rd_en_1 = 1; rd_addr_1 = 3; rd_en_2 = 1; rd_addr_2 = 6; dst_en = 1; dst_addr = 4;
    rst = 1;
    step();
    step();
    chk("rst_rf_write_en", {31'b0, rf_write_en}, 0);
    chk("rst_busy_vec", busy_vec, 0);
    chk("rst_hazard_stall", {31'b0, hazard_stall}, 0);
    chk("rst_pipe_hold", {31'b0, pipe_hold}, 0);
    chk("rst_lu_ready", {31'b0, lu_ready}, 0);
    rst = 0;
    lu_valid = 0;
    idle();
    mon_on = 1;
    pipe_wen = 1; pipe_waddr = 5; pipe_wdata = 32'hA5A5_0001;
    step();
    idle();
    step();
    issue_en = 1; issue_addr = 7;
    step();
    issue_en = 0; rd_en_1 = 1; rd_addr_1 = 7;
    step();
    chk("stall_r7", {31'b0, hazard_stall}, 1);
    step();
    present_lu(32'h1234);
    step();
    chk("busy_r7_cleared", {31'b0, busy_vec[7]}, 0);
    chk("stall_r7_cleared", {31'b0, hazard_stall}, 0);
    idle();
    step();
    issue_en = 1; issue_addr = 9;
    step();
    present_lu(32'h9999_0001);
    issue_en = 1; issue_addr = 9;
    step();
    issue_en = 0;
    chk("busy_r9_kept", {31'b0, busy_vec[9]}, 1);
    present_lu(32'h9999_0002);
    step();
    step();
    issue_en = 1; issue_addr = 3;
    step();
    idle();
    pipe_wen = 1;
    present_lu(32'hBEEF);
    for (int i = 0; i < 20; i++) begin
      pipe_waddr = 5'($urandom);
      pipe_wdata = $urandom;
      #1;
      chk("starve_lu_ready", {31'b0, lu_ready}, {31'b0, GUARD && i == SM});
      chk("starve_pipe_hold", {31'b0, pipe_hold}, {31'b0, GUARD && i == SM});
      step();
    end
    idle();
    for (int i = 0; i < 3; i++) step();
    for (int n = 0; n < 3000; n++) begin
      if (n == 1500) reset_run(2);
      pipe_wen = $urandom_range(0, 99) < 60;
      pipe_waddr = 5'($urandom);
      pipe_wdata = $urandom;
      rd_en_1 = 1'($urandom); rd_addr_1 = 5'($urandom);
      rd_en_2 = 1'($urandom); rd_addr_2 = 5'($urandom);
      dst_en = 1'($urandom); dst_addr = 5'($urandom);
      issue_en = 0;
      if ($urandom_range(0, 3) == 0 && pend_q.size() < 6)
        for (int t = 0; t < 8 && !issue_en; t++) begin
          issue_addr = 5'($urandom);
          issue_en = !m_busy[issue_addr];
        end
      if ($urandom_range(0, 1) == 1) present_lu($urandom);
      step();
    end
    idle();
    for (int t = 0; t < 100 && (pend_q.size() > 0 || lu_valid); t++) begin
      present_lu($urandom);
      step();
    end
    chk("lu_drained", pend_q.size() + {31'b0, lu_valid}, 0);
    step();
    step();
    chk("exp_q_empty", exp_q.size(), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
